uex_mutex_arb: RTL and testbench
================================

// Module: uex_mutex_arb
// PURPOSE
//  Hardware mutex manager shared by N_REQ cores running uex threads.
//  Holds N_MUTEX lock slots, each with a busy flag and an owner ID.
//  Arbitrates lock/unlock requests round-robin, one grant per cycle.
//  Blocked lockers stay pending until the slot frees. Backs the uex_mutex services in HW.
// PARAMETERS
//  N_REQ     4     number of requesters (cores), >=2
//  N_MUTEX   8     number of mutex slots, >=1
//  IDW       3     mutex index width, = max(1,$clog2(N_MUTEX))
//  HOLD_MAX  1024  watchdog hold limit in cycles (used only with UEX_MUTEX_WDOG_EN)
// PORTS
//  clock        in   1            system clock, rising edge
//  reset        in   1            asynchronous, active-high
//  req_valid    in   N_REQ        per-requester request, held until req_ready
//  req_op       in   N_REQ        1=lock, 0=unlock; stable while req_valid
//  req_id       in   N_REQ*IDW    mutex index; requester r uses [r*IDW +: IDW]
//  req_ready    out  N_REQ        1-cycle completion pulse to the serviced requester
//  rsp_err      out  N_REQ        error flag, valid only with req_ready
//  mutex_busy   out  N_MUTEX      per-slot held flag (registered)
//  wdog_expire  out  N_MUTEX      forced-release pulse (tied 0 without the macro)
// BEHAVIOUR
//  - Reset: all slots FREE, owner=0, req_ready=0, rsp_err=0, mutex_busy=0,
//    wdog_expire=0, rr_ptr=0. Async assert clears any in-flight grant. Nothing is replayed.
//  - Slot state: FREE or HELD(owner). Transitions occur only on a serviced request or a watchdog expiry.
//  - Eligible requester r in cycle T:
//    - req_valid[r]=1 and req_ready[r]=0. The ready mask stops double service of a held request.
//    - Unlock requests are always eligible.
//    - A lock is eligible only if its slot is FREE at T.
//  - Winner is the first eligible requester searching from rr_ptr upward, with wrap. rr_ptr <= winner+1 mod N_REQ.
//    With no winner, rr_ptr holds.
//  - Winner is committed at edge T+1; req_ready[winner]=1 during T+1 only. Latency 1 cycle minimum.
//  - Lock on a FREE slot: slot<=HELD(winner), rsp_err=0.
//  - Unlock, slot HELD by the winner: slot<=FREE, rsp_err=0.
//  - Unlock of a FREE slot, or one held by another requester: no state change, rsp_err=1.
//  - Lock of a slot already owned by the requester is not eligible. It blocks forever (non-recursive).
//  - Ineligible locks stay pending with req_ready=0. The requester must keep req_valid and req_id stable.
//  - Only one request is serviced per cycle.
//    - Unlock(A) and lock(A) pending together: the lock sees HELD at T. It can win no earlier than T+1.
//    - Its req_ready then appears at T+2 at the earliest.
//  - req_id >= N_MUTEX: serviced as an unlock error (rsp_err=1, no state change), for either op.
//  - mutex_busy reflects slot state after each edge. It updates in the same cycle req_ready is seen.
//  - Starvation-free: a freed slot goes to pending lockers in round-robin order from rr_ptr.
// CONFIGURATION
//  UEX_MUTEX_WDOG_EN defined:
//    - Each slot has a hold counter, cleared on lock and incremented each cycle while HELD.
//    - When the count reaches HOLD_MAX-1, the slot is forced FREE at the next edge and wdog_expire[slot] pulses 1 cycle.
//    - A later unlock from the former owner returns rsp_err=1.
//    - An expiry has priority over a grant to the same slot in the same cycle. A lock may win the following cycle.
//  UEX_MUTEX_WDOG_EN undefined: no counters, wdog_expire=0 always, and HOLD_MAX is ignored.
// TESTING
//  1 Basic: r0 lock id2 -> req_ready[0] 1 cycle later, rsp_err=0, mutex_busy=8'h04.
//    Then r0 unlock id2 -> rsp_err=0, mutex_busy=0.
//  2 Contention: r0 holds id1. r1 and r2 lock id1. r0 unlocks.
//    r1 is granted first (rr from 1), then r2 only after r1 unlocks. No req_ready while blocked.
//  3 Round robin: r0..r3 lock distinct ids 0..3 in the same cycle.
//    req_ready goes 0,1,2,3 on consecutive cycles, and mutex_busy ends at 8'h0F.
//  4 Errors: r3 unlocks FREE id5 -> rsp_err=1. r1 unlocks id0 held by r0 -> rsp_err=1, mutex_busy[0] stays 1.
//    Lock id 9 with N_MUTEX=8 -> rsp_err=1.
//  5 Reset mid-op: assert reset while 3 slots are held and 2 lockers are pending.
//    All outputs go 0 immediately, and after release the first lock is granted with no stale ownership.
//  6 WDOG (macro on, HOLD_MAX=16): r0 locks id4 and holds it.
//    wdog_expire[4] pulses 16 cycles after the grant edge. A pending r2 lock on id4 is then granted.
//    r0's unlock of id4 -> rsp_err=1.

Source files
------------

// File: rtl/uex_mutex_arb.sv
// uex_mutex_arb: hardware mutex manager for the uex_mutex services.
// N_MUTEX lock slots (busy flag + owner ID) shared by N_REQ requesters.
// Lock/unlock requests are arbitrated round-robin, one grant per cycle.
// A lock on a held slot stays pending until the slot frees; locks are
// non-recursive, so re-locking an owned slot blocks forever.
// Optional feature: define UEX_MUTEX_WDOG_EN to add a per-slot hold
// watchdog that force-frees a slot after HOLD_MAX cycles held and pulses
// wdog_expire for that slot. Without the macro wdog_expire is tied low.
module uex_mutex_arb #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned N_MUTEX  = 8,
  parameter int unsigned IDW      = 3,
  parameter int unsigned HOLD_MAX = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_op,
  input  logic [N_REQ*IDW-1:0]   req_id,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_err,
  output logic [N_MUTEX-1:0]     mutex_busy,
  output logic [N_MUTEX-1:0]     wdog_expire
);

  localparam int unsigned RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SW = (N_MUTEX > 1) ? $clog2(N_MUTEX) : 1;

  // Reject parameter sets the datapath cannot represent.
  if (N_REQ < 2 || N_MUTEX < 1 || IDW < SW || HOLD_MAX < 1) begin : g_bad_params
    $error("uex_mutex_arb: illegal parameter combination");
  end

  logic [RW-1:0]      rr_ptr_q;
  logic [RW-1:0]      owner_q [N_MUTEX];

  logic [N_REQ-1:0]   elig_c;
  logic [N_REQ-1:0]   inr_c;
  logic [SW-1:0]      slot_c [N_REQ];
  logic [N_MUTEX-1:0] expiring_c;

  logic               win_vld_c;
  logic [RW-1:0]      win_idx_c;
  logic [RW-1:0]      cand_c;
  logic               win_op_c;
  logic               win_inr_c;
  logic [SW-1:0]      win_slot_c;

  // Per-requester decode and eligibility; the ready mask blocks re-service
  // of a request whose completion pulse is showing this cycle.
  always_comb begin
    elig_c = '0;
    inr_c  = '0;
    for (int r = 0; r < N_REQ; r++) begin
      slot_c[r] = SW'(req_id[r*IDW +: IDW]);
      inr_c[r]  = (32'(req_id[r*IDW +: IDW]) < N_MUTEX);
      if (req_valid[r] && !req_ready[r]) begin
        if (!inr_c[r]) begin
          // Out-of-range index completes as an error regardless of op.
          elig_c[r] = 1'b1;
        end else if (expiring_c[slot_c[r]]) begin
          // A slot being force-freed this edge accepts no grant.
          elig_c[r] = 1'b0;
        end else if (!req_op[r] || !mutex_busy[slot_c[r]]) begin
          elig_c[r] = 1'b1;
        end
      end
    end
  end

  // Round-robin search from rr_ptr upward with wrap.
  always_comb begin
    win_vld_c = 1'b0;
    win_idx_c = '0;
    cand_c    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_c = RW'((32'(rr_ptr_q) + 32'(k)) % N_REQ);
      if (!win_vld_c && elig_c[cand_c]) begin
        win_vld_c = 1'b1;
        win_idx_c = cand_c;
      end
    end
  end

  // Winner's request fields.
  always_comb begin
    win_op_c   = req_op[win_idx_c];
    win_inr_c  = inr_c[win_idx_c];
    win_slot_c = slot_c[win_idx_c];
  end

  // Commit the winner: slot state, owner, completion pulse and rr pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      req_ready  <= '0;
      rsp_err    <= '0;
      mutex_busy <= '0;
      for (int s = 0; s < N_MUTEX; s++) begin
        owner_q[s] <= '0;
      end
    end else begin
      req_ready <= '0;
      rsp_err   <= '0;
      for (int s = 0; s < N_MUTEX; s++) begin
        if (expiring_c[s]) begin
          mutex_busy[s] <= 1'b0;
        end
      end
      if (win_vld_c) begin
        req_ready[win_idx_c] <= 1'b1;
        rr_ptr_q <= (32'(win_idx_c) == N_REQ - 1) ? '0 : win_idx_c + RW'(1);
        if (!win_inr_c) begin
          rsp_err[win_idx_c] <= 1'b1;
        end else if (win_op_c) begin
          mutex_busy[win_slot_c] <= 1'b1;
          owner_q[win_slot_c]    <= win_idx_c;
        end else if (mutex_busy[win_slot_c] && (owner_q[win_slot_c] == win_idx_c)) begin
          mutex_busy[win_slot_c] <= 1'b0;
        end else begin
          rsp_err[win_idx_c] <= 1'b1;
        end
      end
    end
  end

`ifdef UEX_MUTEX_WDOG_EN
  localparam int unsigned CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  logic [CW-1:0] hold_cnt_q [N_MUTEX];

  // A held slot whose count has reached HOLD_MAX-1 is freed at this edge.
  always_comb begin
    expiring_c = '0;
    for (int s = 0; s < N_MUTEX; s++) begin
      expiring_c[s] = mutex_busy[s] && (32'(hold_cnt_q[s]) == HOLD_MAX - 1);
    end
  end

  // Hold counters: cleared on a granted lock, counting while held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_expire <= '0;
      for (int s = 0; s < N_MUTEX; s++) begin
        hold_cnt_q[s] <= '0;
      end
    end else begin
      wdog_expire <= expiring_c;
      for (int s = 0; s < N_MUTEX; s++) begin
        if (win_vld_c && win_op_c && win_inr_c && (win_slot_c == SW'(s))) begin
          hold_cnt_q[s] <= '0;
        end else if (mutex_busy[s] && !expiring_c[s]) begin
          hold_cnt_q[s] <= hold_cnt_q[s] + CW'(1);
        end
      end
    end
  end
`else
  assign expiring_c  = '0;
  assign wdog_expire = '0;
`endif

endmodule

// File: tb/tb_uex_mutex_arb.sv
// Testbench for uex_mutex_arb: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the lock rules.
module tb_uex_mutex_arb;

  localparam int N_REQ   = 4;
  localparam int N_MUTEX = 8;
  localparam int IDW     = 4;
  localparam int HOLD    = 16;
`ifdef UEX_MUTEX_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [N_REQ-1:0]     req_valid = '0;
  logic [N_REQ-1:0]     req_op = '0;
  logic [N_REQ*IDW-1:0] req_id = '0;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ-1:0]     rsp_err;
  logic [N_MUTEX-1:0]   mutex_busy;
  logic [N_MUTEX-1:0]   wdog_expire;

  int total = 0;
  int bad   = 0;

  // Model state: owner per slot (-1 = free), grant time, rr pointer.
  int               m_own   [N_MUTEX];
  int               m_since [N_MUTEX];
  int               m_rr;
  int               cyc;
  logic [N_REQ-1:0]   m_rdy, e_rdy, e_err;
  logic [N_MUTEX-1:0] e_busy, e_exp;

  uex_mutex_arb #(
    .N_REQ(N_REQ), .N_MUTEX(N_MUTEX), .IDW(IDW), .HOLD_MAX(HOLD)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_id(req_id),
    .req_ready(req_ready), .rsp_err(rsp_err),
    .mutex_busy(mutex_busy), .wdog_expire(wdog_expire)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int r, input bit op, input int id);
    req_valid[r] = 1'b1;
    req_op[r] = op;
    req_id[r*IDW +: IDW] = IDW'(id);
  endtask

  task automatic clr_req(input int r);
    req_valid[r] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_id = '0;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic model_reset();
    for (int s = 0; s < N_MUTEX; s++) begin
      m_own[s] = -1;
      m_since[s] = 0;
    end
    m_rr = 0;
    cyc = 0;
    m_rdy = '0;
  endtask

  // One clock of the lock rules, from the inputs present before the edge.
  task automatic model_step();
    bit exp_now [N_MUTEX];
    int win;
    int id;
    int c;
    bit ok;
    e_rdy = '0;
    e_err = '0;
    e_exp = '0;
    win = -1;
    for (int s = 0; s < N_MUTEX; s++)
      exp_now[s] = WDOG && (m_own[s] >= 0) && (cyc - m_since[s] == HOLD - 1);
    for (int k = 0; k < N_REQ; k++) begin
      c = (m_rr + k) % N_REQ;
      id = int'(req_id[c*IDW +: IDW]);
      ok = req_valid[c] && !m_rdy[c] &&
           ((id >= N_MUTEX) || (!exp_now[id] && (!req_op[c] || m_own[id] < 0)));
      if (win < 0 && ok) win = c;
    end
    for (int s = 0; s < N_MUTEX; s++) begin
      if (exp_now[s]) begin
        m_own[s] = -1;
        e_exp[s] = 1'b1;
      end
    end
    if (win >= 0) begin
      id = int'(req_id[win*IDW +: IDW]);
      e_rdy[win] = 1'b1;
      m_rr = (win + 1) % N_REQ;
      if (id >= N_MUTEX) e_err[win] = 1'b1;
      else if (req_op[win]) begin
        m_own[id] = win;
        m_since[id] = cyc + 1;
      end else if (m_own[id] == win) m_own[id] = -1;
      else e_err[win] = 1'b1;
    end
    for (int s = 0; s < N_MUTEX; s++) e_busy[s] = (m_own[s] >= 0);
    m_rdy = e_rdy;
    cyc++;
  endtask

  // Observation groups below are {req_ready, rsp_err, mutex_busy} as 16'hRE_BB.
  task automatic test_reset();
    do_reset();
    total++;
    if ({req_ready, rsp_err, mutex_busy, wdog_expire} !== 24'h0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=000000", {req_ready, rsp_err, mutex_busy, wdog_expire});
    end
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_idle got=%h exp=0000", {req_ready, rsp_err, mutex_busy});
    end
  endtask

  task automatic test_basic();
    do_reset();
    set_req(0, 1'b1, 2);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h1004) begin
      bad++; $display("FAIL basic_lock got=%h exp=1004", {req_ready, rsp_err, mutex_busy});
    end
    set_req(0, 1'b0, 2);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h0004) begin
      bad++; $display("FAIL basic_mask got=%h exp=0004", {req_ready, rsp_err, mutex_busy});
    end
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h1000) begin
      bad++; $display("FAIL basic_unlock got=%h exp=1000", {req_ready, rsp_err, mutex_busy});
    end
    clr_req(0);
  endtask

  task automatic test_contention();
    do_reset();
    set_req(0, 1'b1, 1);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h1002) begin
      bad++; $display("FAIL cont_own got=%h exp=1002", {req_ready, rsp_err, mutex_busy});
    end
    clr_req(0);
    set_req(1, 1'b1, 1);
    set_req(2, 1'b1, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({req_ready, rsp_err, mutex_busy} !== 16'h0002) begin
        bad++; $display("FAIL cont_blocked%0d got=%h exp=0002", i, {req_ready, rsp_err, mutex_busy});
      end
    end
    set_req(0, 1'b0, 1);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h1000) begin
      bad++; $display("FAIL cont_unlock got=%h exp=1000", {req_ready, rsp_err, mutex_busy});
    end
    clr_req(0);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h2002) begin
      bad++; $display("FAIL cont_r1_grant got=%h exp=2002", {req_ready, rsp_err, mutex_busy});
    end
    clr_req(1);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h0002) begin
      bad++; $display("FAIL cont_r2_blocked got=%h exp=0002", {req_ready, rsp_err, mutex_busy});
    end
    set_req(1, 1'b0, 1);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h2000) begin
      bad++; $display("FAIL cont_r1_unlock got=%h exp=2000", {req_ready, rsp_err, mutex_busy});
    end
    clr_req(1);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h4002) begin
      bad++; $display("FAIL cont_r2_grant got=%h exp=4002", {req_ready, rsp_err, mutex_busy});
    end
    clr_req(2);
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_tab [4];
    exp_tab[0] = 16'h1001;
    exp_tab[1] = 16'h2003;
    exp_tab[2] = 16'h4007;
    exp_tab[3] = 16'h800F;
    do_reset();
    for (int r = 0; r < N_REQ; r++) set_req(r, 1'b1, r);
    for (int r = 0; r < N_REQ; r++) begin
      tick();
      total++;
      if ({req_ready, rsp_err, mutex_busy} !== exp_tab[r]) begin
        bad++; $display("FAIL rr_step%0d got=%h exp=%h", r, {req_ready, rsp_err, mutex_busy}, exp_tab[r]);
      end
      clr_req(r);
    end
  endtask

  task automatic test_errors();
    do_reset();
    set_req(3, 1'b0, 5);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h8800) begin
      bad++; $display("FAIL err_unlock_free got=%h exp=8800", {req_ready, rsp_err, mutex_busy});
    end
    clr_req(3);
    set_req(0, 1'b1, 0);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h1001) begin
      bad++; $display("FAIL err_setup_lock got=%h exp=1001", {req_ready, rsp_err, mutex_busy});
    end
    clr_req(0);
    set_req(1, 1'b0, 0);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h2201) begin
      bad++; $display("FAIL err_unlock_other got=%h exp=2201", {req_ready, rsp_err, mutex_busy});
    end
    clr_req(1);
    set_req(2, 1'b1, 9);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h4401) begin
      bad++; $display("FAIL err_lock_range got=%h exp=4401", {req_ready, rsp_err, mutex_busy});
    end
    clr_req(2);
  endtask

  task automatic test_reset_midop();
    logic [15:0] exp_tab [3];
    exp_tab[0] = 16'h1001;
    exp_tab[1] = 16'h2003;
    exp_tab[2] = 16'h4007;
    do_reset();
    for (int r = 0; r < 3; r++) set_req(r, 1'b1, r);
    for (int r = 0; r < 3; r++) begin
      tick();
      total++;
      if ({req_ready, rsp_err, mutex_busy} !== exp_tab[r]) begin
        bad++; $display("FAIL rst_setup%0d got=%h exp=%h", r, {req_ready, rsp_err, mutex_busy}, exp_tab[r]);
      end
      clr_req(r);
    end
    set_req(3, 1'b1, 0);
    set_req(0, 1'b1, 1);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h0007) begin
      bad++; $display("FAIL rst_pending got=%h exp=0007", {req_ready, rsp_err, mutex_busy});
    end
    reset = 1'b1;
    #1;
    total++;
    if ({req_ready, rsp_err, mutex_busy, wdog_expire} !== 24'h0) begin
      bad++; $display("FAIL rst_async got=%h exp=000000", {req_ready, rsp_err, mutex_busy, wdog_expire});
    end
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h1002) begin
      bad++; $display("FAIL rst_first_grant got=%h exp=1002", {req_ready, rsp_err, mutex_busy});
    end
    clr_req(0);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h8003) begin
      bad++; $display("FAIL rst_second_grant got=%h exp=8003", {req_ready, rsp_err, mutex_busy});
    end
    clr_req(3);
    set_req(1, 1'b0, 1);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy} !== 16'h2203) begin
      bad++; $display("FAIL rst_stale_owner got=%h exp=2203", {req_ready, rsp_err, mutex_busy});
    end
    clr_req(1);
  endtask

`ifdef UEX_MUTEX_WDOG_EN
  task automatic test_wdog();
    do_reset();
    set_req(0, 1'b1, 4);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy, wdog_expire} !== 24'h1010_00) begin
      bad++; $display("FAIL wd_lock got=%h exp=101000", {req_ready, rsp_err, mutex_busy, wdog_expire});
    end
    clr_req(0);
    set_req(2, 1'b1, 4);
    for (int i = 1; i < HOLD; i++) begin
      tick();
      total++;
      if ({req_ready, rsp_err, mutex_busy, wdog_expire} !== 24'h0010_00) begin
        bad++; $display("FAIL wd_hold%0d got=%h exp=001000", i, {req_ready, rsp_err, mutex_busy, wdog_expire});
      end
    end
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy, wdog_expire} !== 24'h0000_10) begin
      bad++; $display("FAIL wd_expire got=%h exp=000010", {req_ready, rsp_err, mutex_busy, wdog_expire});
    end
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy, wdog_expire} !== 24'h4010_00) begin
      bad++; $display("FAIL wd_regrant got=%h exp=401000", {req_ready, rsp_err, mutex_busy, wdog_expire});
    end
    clr_req(2);
    set_req(0, 1'b0, 4);
    tick();
    total++;
    if ({req_ready, rsp_err, mutex_busy, wdog_expire} !== 24'h1110_00) begin
      bad++; $display("FAIL wd_stale_unlock got=%h exp=111000", {req_ready, rsp_err, mutex_busy, wdog_expire});
    end
    clr_req(0);
  endtask
`endif

  // Random requester agents: a holder only ever unlocks, so no lock cycle forms.
  task automatic test_random();
    int my_slot [N_REQ];
    int id;
    do_reset();
    model_reset();
    for (int r = 0; r < N_REQ; r++) my_slot[r] = -1;
    for (int t = 0; t < 3000; t++) begin
      model_step();
      tick();
      total++;
      if ({req_ready, rsp_err} !== {e_rdy, e_err}) begin
        bad++; $display("FAIL rnd_resp t=%0d got=%b exp=%b", t, {req_ready, rsp_err}, {e_rdy, e_err});
      end
      total++;
      if (mutex_busy !== e_busy) begin
        bad++; $display("FAIL rnd_busy t=%0d got=%b exp=%b", t, mutex_busy, e_busy);
      end
      total++;
      if (wdog_expire !== e_exp) begin
        bad++; $display("FAIL rnd_wdog t=%0d got=%b exp=%b", t, wdog_expire, e_exp);
      end
      for (int r = 0; r < N_REQ; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          id = int'(req_id[r*IDW +: IDW]);
          if (req_op[r] && !rsp_err[r] && id < N_MUTEX) my_slot[r] = id;
          else if (!req_op[r] && id == my_slot[r]) my_slot[r] = -1;
          clr_req(r);
        end
        if (!req_valid[r] && $urandom_range(2) == 0) begin
          if (my_slot[r] >= 0 && $urandom_range(7) != 0) set_req(r, 1'b0, my_slot[r]);
          else if ($urandom_range(7) == 0) set_req(r, 1'b0, int'($urandom_range(N_MUTEX + 1)));
          else if (my_slot[r] < 0) set_req(r, 1'b1, int'($urandom_range(N_MUTEX + 1)));
          else set_req(r, 1'b0, my_slot[r]);
        end
      end
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_contention();
    test_round_robin();
    test_errors();
    test_reset_midop();
`ifdef UEX_MUTEX_WDOG_EN
    test_wdog();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
